uart_rx_cfg: RTL and testbench

- Parametrised second-generation UART receiver: oversampled serial input to parallel word.
- Configurable data width, oversampling ratio, parity and stop-bit count; 3-sample majority voting; registered per-frame error flags.
- Sits between the pad-side RX_IN line and the system-side consumer, which is a register bank or FIFO.
- Replaces the fixed 8-bit receiver in the UART subsystem.

---
 rtl/uart_rx_cfg.sv | 211 +++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// Oversampled UART receiver: configurable width, prescale, parity and stop bits, 3-sample vote.
// Define UART_RX_BREAK_DETECT_EN to add the BRK_DET output and the post-break idle lockout.
module uart_rx_cfg #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned PRESCALE_MAX = 32
) (
  input  logic                  CLK,
  input  logic                  RST_n,
  input  logic                  RX_IN,
  input  logic [5:0]            Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_Valid,
  output logic                  PAR_ERR,
  output logic                  STP_ERR,
`ifdef UART_RX_BREAK_DETECT_EN
  output logic                  BRK_DET,
`endif
  output logic                  BUSY
);
  localparam int unsigned CW = $clog2(PRESCALE_MAX);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                state_q;
  logic [1:0]            sync_q;
  logic                  rx_s;
  logic [CW-1:0]         edge_cnt_q, pm1_q, half_q;
  logic [3:0]            bit_cnt_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [2:0]            samp_q;
  logic                  par_en_q, par_typ_q, stop2_q, par_err_q, stp_err_q;
  logic [6:0]            ps_even, ps_clamp;
  logic                  at_end, at_dec, vote, last_stop, stp_bad;
  logic                  unused_ps;
`ifdef UART_RX_BREAK_DETECT_EN
  logic                  brk_ok_q, brk_wait_q, brk_now;
`endif

  assign unused_ps = Prescale[0];
  assign rx_s      = sync_q[1];

  always_comb begin
    ps_even  = {1'b0, Prescale[5:1], 1'b0};
    ps_clamp = ps_even;
    if (ps_even < 7'd8) begin
      ps_clamp = 7'd8;
    end else if (ps_even > 7'(PRESCALE_MAX)) begin
      ps_clamp = 7'(PRESCALE_MAX);
    end
  end

  assign at_end    = (edge_cnt_q == pm1_q);
  assign at_dec    = (edge_cnt_q == half_q + CW'(2));
  assign vote      = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
  // bit_cnt counts stop bits in StStop; the final one is index STOP2
  assign last_stop = (bit_cnt_q[0] == stop2_q);
  assign stp_bad   = stp_err_q | ~vote;
`ifdef UART_RX_BREAK_DETECT_EN
  assign brk_now   = brk_ok_q & (bit_cnt_q[0] | ~vote);
`endif

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q    <= StIdle;
      sync_q     <= 2'b11;
      edge_cnt_q <= '0;
      pm1_q      <= '0;
      half_q     <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      samp_q     <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      stop2_q    <= 1'b0;
      par_err_q  <= 1'b0;
      stp_err_q  <= 1'b0;
      P_DATA     <= '0;
      DATA_Valid <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
      BUSY       <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      BRK_DET    <= 1'b0;
      brk_ok_q   <= 1'b0;
      brk_wait_q <= 1'b0;
`endif
    end else begin
      sync_q     <= {sync_q[0], RX_IN};
      DATA_Valid <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      BRK_DET    <= 1'b0;
`endif
      if (state_q != StIdle) begin
        edge_cnt_q <= at_end ? '0 : edge_cnt_q + CW'(1);
        if (edge_cnt_q == half_q - CW'(1)) samp_q[0] <= rx_s;
        if (edge_cnt_q == half_q)          samp_q[1] <= rx_s;
        if (edge_cnt_q == half_q + CW'(1)) samp_q[2] <= rx_s;
      end
      unique case (state_q)
        StIdle: begin
`ifdef UART_RX_BREAK_DETECT_EN
          if (brk_wait_q) begin
            if (!rx_s) begin
              edge_cnt_q <= '0;
            end else if (at_end) begin
              brk_wait_q <= 1'b0;
              edge_cnt_q <= '0;
            end else begin
              edge_cnt_q <= edge_cnt_q + CW'(1);
            end
          end else
`endif
          if (!rx_s) begin
            state_q    <= StStart;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            pm1_q      <= CW'(ps_clamp - 7'd1);
            half_q     <= CW'(ps_clamp >> 1);
            par_en_q   <= PAR_EN;
            par_typ_q  <= PAR_TYP;
            stop2_q    <= STOP2;
            par_err_q  <= 1'b0;
            stp_err_q  <= 1'b0;
            BUSY       <= 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
            brk_ok_q   <= 1'b1;
`endif
          end
        end
        StStart: begin
          if (at_dec && vote) begin
            state_q <= StIdle;
            BUSY    <= 1'b0;
          end else if (at_end) begin
            state_q   <= StData;
            bit_cnt_q <= '0;
          end
        end
        StData: begin
          if (at_dec) begin
            shift_q <= {vote, shift_q[DATA_WIDTH-1:1]};
`ifdef UART_RX_BREAK_DETECT_EN
            brk_ok_q <= brk_ok_q & ~vote;
`endif
          end
          if (at_end) begin
            if (bit_cnt_q == 4'(DATA_WIDTH - 1)) begin
              state_q   <= par_en_q ? StParity : StStop;
              bit_cnt_q <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
        end
        StParity: begin
          if (at_dec) begin
            par_err_q <= vote ^ (^shift_q) ^ par_typ_q;
`ifdef UART_RX_BREAK_DETECT_EN
            brk_ok_q  <= brk_ok_q & ~vote;
`endif
          end
          if (at_end) begin
            state_q   <= StStop;
            bit_cnt_q <= '0;
          end
        end
        StStop: begin
          if (at_dec) begin
            if (last_stop) begin
              // Leave mid-bit so a start edge right after the stop bit is not missed
`ifdef UART_RX_BREAK_DETECT_EN
              if (brk_now) begin
                BRK_DET    <= 1'b1;
                PAR_ERR    <= par_err_q;
                brk_wait_q <= 1'b1;
                edge_cnt_q <= '0;
              end else
`endif
              if (par_err_q || stp_bad) begin
                PAR_ERR <= par_err_q;
                STP_ERR <= stp_bad;
              end else begin
                P_DATA     <= shift_q;
                DATA_Valid <= 1'b1;
              end
              state_q <= StIdle;
              BUSY    <= 1'b0;
            end else begin
              stp_err_q <= stp_bad;
`ifdef UART_RX_BREAK_DETECT_EN
              brk_ok_q  <= brk_ok_q & ~vote;
`endif
            end
          end else if (at_end) begin
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          BUSY    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: per-cycle line samples built from frame-level rules, outputs
// checked against a frame-level reference model (two instances, DATA_WIDTH 8 and 5).
module tb_uart_rx_cfg;
  logic       CLK = 1'b0;
  logic       RST_n = 1'b0;
  logic       RX_IN = 1'b1;
  logic [5:0] Prescale = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       STOP2 = 1'b0;

  logic [7:0] pd8;
  logic       dv8, pe8, se8, busy8;
  logic [4:0] pd5;
  logic       dv5, pe5, se5, busy5;

  int          n_assert = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;

  typedef struct packed {
    logic [8:0]  data;
    logic        dv;
    logic        pe;
    logic        se;
    logic [31:0] cyc;
  } evt_t;

  evt_t ev8[$];
  evt_t ev5[$];
  bit   stream[$];
  logic [8:0] exp_pd8 = '0;
  logic [8:0] exp_pd5 = '0;
  int busy_run = 0, busy_max = 0, busy_clr_req = 0, busy_clr_seen = 0;

  uart_rx_cfg #(.DATA_WIDTH(8), .PRESCALE_MAX(32)) dut8 (
    .CLK(CLK), .RST_n(RST_n), .RX_IN(RX_IN), .Prescale(Prescale), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .STOP2(STOP2), .P_DATA(pd8), .DATA_Valid(dv8), .PAR_ERR(pe8),
    .STP_ERR(se8), .BUSY(busy8)
  );

  uart_rx_cfg #(.DATA_WIDTH(5), .PRESCALE_MAX(32)) dut5 (
    .CLK(CLK), .RST_n(RST_n), .RX_IN(RX_IN), .Prescale(Prescale), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .STOP2(STOP2), .P_DATA(pd5), .DATA_Valid(dv5), .PAR_ERR(pe5),
    .STP_ERR(se5), .BUSY(busy5)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (dv8 || pe8 || se8)
      ev8.push_back('{data: {1'b0, pd8}, dv: dv8, pe: pe8, se: se8, cyc: cyc});
    if (dv5 || pe5 || se5)
      ev5.push_back('{data: {4'b0, pd5}, dv: dv5, pe: pe5, se: se5, cyc: cyc});
    if (busy_clr_seen != busy_clr_req) begin
      busy_clr_seen = busy_clr_req;
      busy_run = 0;
      busy_max = 0;
    end
    if (busy8) begin
      busy_run++;
      if (busy_run > busy_max) busy_max = busy_run;
    end else begin
      busy_run = 0;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_p(input int ps);
    int e;
    e = ps & ~1;
    if (e < 8) e = 8;
    if (e > 32) e = 32;
    return e;
  endfunction

  function automatic int ecount(input int dw);
    return (dw == 8) ? ev8.size() : ev5.size();
  endfunction

  function automatic evt_t eget(input int dw, input int i);
    return (dw == 8) ? ev8[i] : ev5[i];
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) stream.push_back(1'b1);
  endtask

  // One line sample per clock; optional single corrupted sample per bit near its centre
  task automatic build(input logic [8:0] data, input int dw, input int p, input bit pe,
                       input bit pbit, input bit s2, input bit st1, input bit st2,
                       input bit flip);
    bit bits[$];
    int fo;
    bits.push_back(1'b0);
    for (int i = 0; i < dw; i++) bits.push_back(data[i]);
    if (pe) bits.push_back(pbit);
    bits.push_back(st1);
    if (s2) bits.push_back(st2);
    foreach (bits[b]) begin
      fo = flip ? int'($urandom_range(p / 2 + 2, 1)) : -1;
      for (int k = 0; k < p; k++) stream.push_back((k == fo) ? ~bits[b] : bits[b]);
    end
  endtask

  task automatic play(input int n, input bit scramble, output int unsigned st);
    logic [5:0] ps0;
    logic       a, b, c;
    ps0 = Prescale; a = PAR_EN; b = PAR_TYP; c = STOP2;
    st = 0;
    for (int i = 0; i < n && i < stream.size(); i++) begin
      @(negedge CLK);
      RX_IN = stream[i];
      if (i == 0) st = cyc;
      if (scramble && i == stream.size() / 2) begin
        Prescale = 6'($urandom_range(63));
        PAR_EN = ~PAR_EN; PAR_TYP = ~PAR_TYP; STOP2 = ~STOP2;
      end
    end
    Prescale = ps0; PAR_EN = a; PAR_TYP = b; STOP2 = c;
    stream.delete();
  endtask

  task automatic run(input int dw, input string tag, input logic [8:0] data,
                     input logic [5:0] ps, input bit pe, input bit ptyp, input bit s2,
                     input bit bad_par, input bit st1, input bit st2, input bit flip,
                     input bit scramble, output int lat);
    int          p, base, n;
    int unsigned st;
    logic [8:0]  dm, prev;
    bit          pbit, x_pe, x_se, good;
    evt_t        e;
    p = eff_p(int'(ps));
    Prescale = ps; PAR_EN = pe; PAR_TYP = ptyp; STOP2 = s2;
    dm = data & ((9'd1 << dw) - 9'd1);
    pbit = (^dm) ^ ptyp ^ bad_par;
    build(dm, dw, p, pe, pbit, s2, st1, st2, flip);
    idle(3 * p);
    base = ecount(dw);
    play(stream.size(), scramble, st);
    x_pe = pe & bad_par;
    x_se = !st1 | (s2 & !st2);
    good = !x_pe && !x_se;
    prev = (dw == 8) ? exp_pd8 : exp_pd5;
    n = ecount(dw) - base;
    chk({tag, "_count"}, n, 1);
    lat = -1;
    if (n >= 1) begin
      e = eget(dw, base);
      chk({tag, "_valid"}, {31'b0, e.dv}, {31'b0, good});
      chk({tag, "_par_err"}, {31'b0, e.pe}, {31'b0, x_pe});
      chk({tag, "_stp_err"}, {31'b0, e.se}, {31'b0, x_se});
      chk({tag, "_data"}, {23'b0, e.data}, {23'b0, good ? dm : prev});
      lat = int'(e.cyc - st - 1);
    end
    if (good) begin
      if (dw == 8) exp_pd8 = dm;
      else exp_pd5 = dm;
    end
  endtask

  initial begin
    int          lat, base, pr;
    int unsigned st;
    bit          pe, s2, bp, s1, sb;
    evt_t        e1, e2;

    repeat (3) @(negedge CLK);
    chk("rst_pdata", {24'b0, pd8}, 32'h0);
    chk("rst_flags", {28'b0, dv8, pe8, se8, busy8}, 32'h0);
    RST_n = 1'b1;
    repeat (4) @(negedge CLK);

    run(8, "basic", 9'hA5, 6'd8, 0, 0, 0, 0, 1, 1, 0, 0, lat);
    chk("basic_latency", lat, 2 + 8 * 9 + 4 + 3);

    run(8, "par_bad", 9'h3C, 6'd8, 1, 0, 0, 1, 1, 1, 0, 0, lat);
    run(8, "par_good", 9'h3C, 6'd8, 1, 0, 0, 0, 1, 1, 0, 0, lat);
    run(8, "par_odd", 9'h5B, 6'd10, 1, 1, 0, 0, 1, 1, 0, 0, lat);

    // Two-sample low glitch on an idle line at P = 16
    Prescale = 6'd16; PAR_EN = 1'b0; STOP2 = 1'b0;
    busy_clr_req++;
    @(negedge CLK);
    base = ecount(8);
    stream.push_back(1'b0); stream.push_back(1'b0);
    idle(48);
    play(stream.size(), 0, st);
    chk("glitch_pulses", ecount(8) - base, 0);
    chk("glitch_busy_seen", {31'b0, busy_max > 0}, 32'h1);
    chk("glitch_busy_short", {31'b0, busy_max < 16}, 32'h1);

    run(8, "majority", 9'h55, 6'd16, 0, 0, 0, 0, 1, 1, 1, 0, lat);

    // Back-to-back two-stop-bit frames, no idle gap between them
    Prescale = 6'd8; PAR_EN = 1'b0; STOP2 = 1'b1;
    build(9'h01, 8, 8, 0, 0, 1, 1, 1, 0);
    build(9'hFE, 8, 8, 0, 0, 1, 1, 1, 0);
    idle(24);
    base = ecount(8);
    play(stream.size(), 0, st);
    chk("b2b_count", ecount(8) - base, 2);
    if (ecount(8) - base >= 2) begin
      e1 = eget(8, base);
      e2 = eget(8, base + 1);
      chk("b2b_first", {22'b0, e1.dv, e1.data}, {22'b0, 1'b1, 9'h01});
      chk("b2b_second", {22'b0, e2.dv, e2.data}, {22'b0, 1'b1, 9'hFE});
      chk("b2b_spacing", e2.cyc - e1.cyc, 32'd88);
      exp_pd8 = 9'hFE;
    end

    run(8, "stop2_low", 9'($urandom_range(255)), 6'd8, 0, 0, 1, 0, 1, 0, 0, 0, lat);
    run(8, "after_stop2", 9'($urandom_range(255)), 6'd8, 0, 0, 1, 0, 1, 1, 0, 0, lat);
    run(8, "stop1_low", 9'($urandom_range(255)), 6'd12, 1, 0, 0, 0, 0, 1, 0, 0, lat);

    run(8, "ps_low", 9'($urandom_range(255)), 6'd4, 0, 0, 0, 0, 1, 1, 0, 0, lat);
    run(8, "ps_odd", 9'($urandom_range(255)), 6'd17, 0, 0, 0, 0, 1, 1, 0, 0, lat);
    run(8, "ps_high", 9'($urandom_range(255)), 6'd50, 0, 0, 0, 0, 1, 1, 0, 0, lat);
    run(8, "cfg_change", 9'($urandom_range(255)), 6'd12, 1, 1, 1, 0, 1, 1, 0, 1, lat);

    for (int i = 0; i < 6; i++) begin
      pr = int'($urandom_range(63));
      pe = 1'($urandom_range(1));
      s2 = 1'($urandom_range(1));
      bp = pe && ($urandom_range(3) == 0);
      s1 = ($urandom_range(4) != 0);
      sb = s2 ? ($urandom_range(4) != 0) : 1'b1;
      run(8, $sformatf("rand%0d", i), 9'($urandom_range(255)), 6'(pr), pe,
          1'($urandom_range(1)), s2, bp, s1, sb, 1'($urandom_range(1)),
          1'($urandom_range(1)), lat);
    end

    // Narrow instance; reset first so it starts the section from IDLE
    @(negedge CLK);
    RST_n = 1'b0;
    repeat (2) @(negedge CLK);
    RST_n = 1'b1;
    exp_pd8 = '0;
    exp_pd5 = '0;
    repeat (4) @(negedge CLK);
    run(5, "dw5_1f", 9'h1F, 6'd32, 0, 0, 0, 0, 1, 1, 0, 0, lat);
    chk("dw5_latency", lat, 2 + 32 * 6 + 16 + 3);

    Prescale = 6'd32; PAR_EN = 1'b0; STOP2 = 1'b0;
    build(9'h0A, 5, 32, 0, 0, 0, 1, 1, 0);
    base = ecount(5);
    play(32 * 3 + 10, 0, st);
    @(negedge CLK);
    RST_n = 1'b0;
    RX_IN = 1'b1;
    #1;
    chk("midrst_pdata", {27'b0, pd5}, 32'h0);
    chk("midrst_flags", {28'b0, dv5, pe5, se5, busy5}, 32'h0);
    repeat (3) @(negedge CLK);
    RST_n = 1'b1;
    repeat (40) @(negedge CLK);
    chk("midrst_no_pulse", ecount(5) - base, 0);
    run(5, "dw5_after_rst", 9'($urandom_range(31)), 6'd32, 0, 0, 0, 0, 1, 1, 0, 0, lat);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
